uart_tx_scheduler: RTL and testbench
====================================

// Module: uart_tx_scheduler
// PURPOSE
//  Shares one uart_tx byte transmitter between NUM_REQ on-chip requesters (Nios bridge, control_uart, ...).
//  Arbitration is round-robin. Each granted byte is sent as a frame: optional ID header byte, then payload byte.
//  Enforces the tx_start/tx_done handshake and aborts the frame on a transmitter timeout.
//  Runs on the system clock. tx_busy/tx_done come from the transmitter, already synchronised to clk.
// PARAMETERS
//  NUM_REQ      4       number of requesters (2..8)
//  DATA_W       8       byte width
//  HEADER_EN    1       1: send ID header before payload; 0: payload only
//  TIMEOUT_CYC  100000  max clk cycles waiting for tx_done per byte
//  CNT_W        17      timeout counter width (2^CNT_W > TIMEOUT_CYC)
//  localparam ID_W = (NUM_REQ>1) ? $clog2(NUM_REQ) : 1
// PORTS
//  clk          in   1               system clock, single clock domain
//  rst          in   1               asynchronous reset, active-high
//  req_valid    in   NUM_REQ         requester i has a byte pending; level, held until req_ack[i]
//  req_data     in   NUM_REQ*DATA_W  byte of requester i at [i*DATA_W +: DATA_W]
//  req_ack      out  NUM_REQ         one-cycle pulse: byte of requester i latched, may drop valid
//  tx_start     out  1               one-cycle pulse: transmitter loads tx_data
//  tx_data      out  DATA_W          byte to send; stable from tx_start until next tx_start
//  tx_busy      in   1               transmitter shifting; tx_start never issued while high
//  tx_done      in   1               one-cycle pulse: current byte fully sent (stop bit done)
//  grant_id     out  ID_W            requester owning the current/last frame
//  busy         out  1               high in every state except IDLE
//  timeout_err  out  1               one-cycle pulse: frame aborted by timeout
// BEHAVIOUR
//  Reset: state IDLE; outputs tx_start=0, tx_data=0, req_ack=0, grant_id=0, busy=0, timeout_err=0.
//   rr_ptr resets so that requester 0 has first priority.
//  Reset mid-frame drops the frame silently: no ack, no error pulse.
//  FSM: IDLE -> HDR_LOAD -> HDR_WAIT -> DAT_LOAD -> DAT_WAIT -> IDLE.
//   HEADER_EN=0: IDLE goes straight to DAT_LOAD.
//  IDLE, any req_valid set:
//   - grant the first set bit scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
//   - latch req_data slice into hold_reg; set grant_id.
//   - req_ack[g]=1 for exactly the next cycle; rr_ptr <= g+1 (wraps NUM_REQ-1 -> 0).
//  *_LOAD: wait while tx_busy=1; when tx_busy=0, pulse tx_start for one cycle, then go to *_WAIT.
//   - tx_data = header in HDR_LOAD, hold_reg in DAT_LOAD.
//   - header = MSB 1, bits [ID_W-1:0] = grant_id, remaining bits 0 (e.g. 8'h82 for id 2).
//  *_WAIT: cnt increments each cycle from 0.
//   - tx_done=1 -> next state, cnt cleared.
//   - cnt==TIMEOUT_CYC-1 without tx_done -> timeout_err pulse, go to IDLE; payload is not sent.
//   - tx_done and timeout in the same cycle -> done wins, no error.
//  tx_done outside *_WAIT: ignored.
//  req_valid changes after the grant do not affect the frame in flight.
//  Latency from IDLE with tx_busy=0: req_valid -> req_ack +1 cycle; first tx_start +2 cycles.
//  Back-to-back: return to IDLE, then re-arbitrate the next cycle.
//  Fairness: with all requesters valid, grants go 0,1,2,3,0,...; nobody is starved.
// TESTING
//  1. Reset with req_valid=4'b1111.
//     -> all outputs 0 during reset; first grant after release is id 0.
//  2. Only req 2 valid, data 8'h5A, tx_done 10 cycles after each tx_start.
//     -> req_ack=4'b0100 one cycle; tx bytes 8'h82 then 8'h5A; busy low after the 2nd tx_done.
//  3. All four requesters valid continuously.
//     -> grant_id order 0,1,2,3,0; exactly one req_ack bit per frame; tx_start never while tx_busy.
//  4. tx_busy held high 50 cycles at HDR_LOAD.
//     -> tx_start delayed until the cycle after tx_busy falls; tx_data stable throughout.
//  5. TIMEOUT_CYC=20, tx_done withheld.
//     -> timeout_err pulse 20 cycles after tx_start; no payload byte; next arbitration proceeds.
//  6. HEADER_EN=0; rst asserted during DAT_WAIT.
//     -> single tx_start per frame; async reset clears outputs immediately, no error pulse.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin sharing of one uart byte transmitter, ID header + payload per frame.
module uart_tx_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W = 8,
  parameter int HEADER_EN = 1,
  parameter int TIMEOUT_CYC = 100000,
  parameter int CNT_W = 17,
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_busy,
  input  logic                      tx_done,
  output logic [ID_W-1:0]           grant_id,
  output logic                      busy,
  output logic                      timeout_err
);
  typedef enum logic [2:0] {IDLE, HDR_LOAD, HDR_WAIT, DAT_LOAD, DAT_WAIT} state_t;
  state_t state;
  logic [ID_W-1:0] rr_ptr, g;
  logic [DATA_W-1:0] hold_reg, header;
  logic [CNT_W-1:0] cnt;
  logic cnt_last;
  always_comb begin
    g = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (req_valid[idx]) g = ID_W'(idx);
    end
  end
  always_comb begin
    header = '0;
    header[DATA_W-1] = 1'b1;
    header[ID_W-1:0] = grant_id;
  end
  assign cnt_last = cnt == CNT_W'(TIMEOUT_CYC - 1);
  assign busy = state != IDLE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      tx_start <= 1'b0;
      tx_data <= '0;
      req_ack <= '0;
      grant_id <= '0;
      timeout_err <= 1'b0;
      rr_ptr <= '0;
      hold_reg <= '0;
      cnt <= '0;
    end else begin
      tx_start <= 1'b0;
      req_ack <= '0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: if (|req_valid) begin
          grant_id <= g;
          hold_reg <= req_data[int'(g)*DATA_W +: DATA_W];
          req_ack <= NUM_REQ'(1) << g;
          rr_ptr <= (g == ID_W'(NUM_REQ - 1)) ? '0 : g + 1'b1;
          state <= (HEADER_EN != 0) ? HDR_LOAD : DAT_LOAD;
        end
        HDR_LOAD, DAT_LOAD: if (!tx_busy) begin
          tx_start <= 1'b1;
          tx_data <= (state == HDR_LOAD) ? header : hold_reg;
          cnt <= '0;
          state <= (state == HDR_LOAD) ? HDR_WAIT : DAT_WAIT;
        end
        HDR_WAIT, DAT_WAIT: begin
          // tx_done outranks a simultaneous timeout
          if (tx_done) begin
            cnt <= '0;
            state <= (state == HDR_WAIT) ? DAT_LOAD : IDLE;
          end else if (cnt_last) begin
            cnt <= '0;
            timeout_err <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: directed bench; header DUT and payload-only DUT share the stimulus.
module tb_uart_tx_scheduler;
  logic clk = 0, rst = 1, tx_busy = 0, tx_done = 0, use_z = 0;
  logic [3:0] req_valid = 4'hF;
  logic [31:0] req_data = 32'h44332211;
  logic [3:0] req_ack, z_req_ack;
  logic tx_start, z_tx_start, busy, z_busy, timeout_err, z_timeout_err;
  logic [7:0] tx_data, z_tx_data;
  logic [1:0] grant_id, z_grant_id;
  logic ws_start;
  logic [7:0] ws_data;
  logic busy_q = 0;
  logic [3:0] last_ack = 0;
  int checks = 0, errors = 0, ack_total = 0, viol = 0;
  always #5 clk = ~clk;
  uart_tx_scheduler #(.TIMEOUT_CYC(20), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ack(req_ack),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done),
    .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err));
  uart_tx_scheduler #(.HEADER_EN(0), .TIMEOUT_CYC(20), .CNT_W(5)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ack(z_req_ack),
    .tx_start(z_tx_start), .tx_data(z_tx_data), .tx_busy(tx_busy), .tx_done(tx_done),
    .grant_id(z_grant_id), .busy(z_busy), .timeout_err(z_timeout_err));
  always_comb begin
    ws_start = use_z ? z_tx_start : tx_start;
    ws_data = use_z ? z_tx_data : tx_data;
  end
  always @(posedge clk) begin
    busy_q <= tx_busy;
    if (tx_start && busy_q) viol <= viol + 1;
    if (|req_ack) begin
      ack_total <= ack_total + 1;
      last_ack <= req_ack;
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wait_start(input string tag);
    int n = 0;
    while (!ws_start && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, ws_start, 1);
  endtask
  task automatic pulse_done(input int dly);
    tx_busy = 1;
    repeat (dly - 1) @(negedge clk);
    tx_done = 1;
    tx_busy = 0;
    @(negedge clk);
    tx_done = 0;
  endtask
  task automatic do_frame(input logic [7:0] hdr, input logic [7:0] pay, input int dly);
    wait_start("hdr_start");
    chk("hdr_data", tx_data, hdr);
    pulse_done(dly);
    wait_start("pay_start");
    chk("pay_data", tx_data, pay);
    pulse_done(dly);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int a0, n, cnt;
    logic [7:0] d0;
    // 1: reset with all requesters valid
    repeat (3) @(negedge clk);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_req_ack", req_ack, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout_err", timeout_err, 0);
    rst = 0;
    @(negedge clk);
    chk("t1_ack", req_ack, 4'b0001);
    chk("t1_grant", grant_id, 0);
    chk("t1_busy", busy, 1);
    req_valid = 0;
    do_frame(8'h80, 8'h11, 10);
    // 2: only requester 2
    req_valid = 4'b0100;
    req_data = 32'h005A0000;
    @(negedge clk);
    chk("t2_ack", req_ack, 4'b0100);
    chk("t2_grant", grant_id, 2);
    req_valid = 0;
    do_frame(8'h82, 8'h5A, 10);
    chk("t2_busy_low", busy, 0);
    // 3: all valid from a fresh reset, fairness
    rst = 1;
    req_valid = 4'hF;
    req_data = 32'h44332211;
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      a0 = ack_total;
      wait_start("t3_hdr_start");
      chk("t3_grant", grant_id, i % 4);
      chk("t3_hdr", tx_data, 8'h80 | (i % 4));
      pulse_done(4);
      wait_start("t3_pay_start");
      chk("t3_pay", tx_data, 8'h11 * ((i % 4) + 1));
      pulse_done(4);
      chk("t3_ack_count", ack_total - a0, 1);
      chk("t3_ack_bit", last_ack, 4'b0001 << (i % 4));
    end
    // 4: transmitter busy while header is pending
    tx_busy = 1;
    req_valid = 4'b0010;
    req_data = 32'h0000C300;
    @(negedge clk);
    chk("t4_ack", req_ack, 4'b0010);
    req_valid = 0;
    d0 = tx_data;
    n = 0;
    cnt = 0;
    repeat (50) begin
      @(negedge clk);
      n += int'(tx_start);
      cnt += int'(tx_data != d0);
    end
    chk("t4_no_start", n, 0);
    chk("t4_data_stable", cnt, 0);
    tx_busy = 0;
    @(negedge clk);
    chk("t4_start", tx_start, 1);
    chk("t4_hdr", tx_data, 8'h81);
    pulse_done(10);
    wait_start("t4_pay_start");
    chk("t4_pay", tx_data, 8'hC3);
    pulse_done(10);
    // 5: timeout with tx_done withheld
    req_valid = 4'b1000;
    req_data = 32'h77000000;
    @(negedge clk);
    chk("t5_ack", req_ack, 4'b1000);
    req_valid = 0;
    wait_start("t5_hdr_start");
    chk("t5_hdr", tx_data, 8'h83);
    n = 0;
    while (!timeout_err && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t5_timeout_delay", n, 20);
    @(negedge clk);
    chk("t5_err_pulse", timeout_err, 0);
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      cnt += int'(tx_start);
    end
    chk("t5_no_payload", cnt, 0);
    chk("t5_busy_low", busy, 0);
    req_valid = 4'b0001;
    req_data = 32'h00000011;
    @(negedge clk);
    chk("t5_next_ack", req_ack, 4'b0001);
    req_valid = 0;
    do_frame(8'h80, 8'h11, 5);
    chk("no_start_while_busy", viol, 0);
    // 6: payload-only DUT, then reset during DAT_WAIT
    rst = 1;
    @(negedge clk);
    rst = 0;
    use_z = 1;
    req_valid = 4'b0100;
    req_data = 32'h005A0000;
    @(negedge clk);
    chk("t6_ack", z_req_ack, 4'b0100);
    req_valid = 0;
    wait_start("t6_start");
    chk("t6_data", z_tx_data, 8'h5A);
    chk("t6_grant", z_grant_id, 2);
    pulse_done(6);
    chk("t6_busy_low", z_busy, 0);
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      cnt += int'(z_tx_start);
    end
    chk("t6_single_start", cnt, 0);
    req_valid = 4'b0001;
    req_data = 32'h00000011;
    @(negedge clk);
    chk("t6_ack2", z_req_ack, 4'b0001);
    req_valid = 0;
    wait_start("t6_start2");
    repeat (3) @(negedge clk);
    rst = 1;
    #1;
    chk("t6_rst_busy", z_busy, 0);
    chk("t6_rst_data", z_tx_data, 0);
    chk("t6_rst_grant", z_grant_id, 0);
    cnt = 0;
    n = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (40) begin
      @(negedge clk);
      cnt += int'(z_timeout_err);
      n += int'(z_req_ack != 0);
    end
    chk("t6_no_err", cnt, 0);
    chk("t6_no_ack", n, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
